// File: rtl/mips_defs.sv
// Shared MIPS opcode/funct constants and load-kind decode, used by every stage controller.
package mips_defs;

  localparam logic [5:0] OpSpecial = 6'b000000;
  localparam logic [5:0] OpJal     = 6'b000011;
  localparam logic [5:0] OpLb      = 6'b100000;
  localparam logic [5:0] OpLh      = 6'b100001;
  localparam logic [5:0] OpLw      = 6'b100011;
  localparam logic [5:0] OpLbu     = 6'b100100;
  localparam logic [5:0] OpLhu     = 6'b100101;
  localparam logic [5:0] OpSb      = 6'b101000;
  localparam logic [5:0] OpSh      = 6'b101001;
  localparam logic [5:0] OpSw      = 6'b101011;

  localparam logic [5:0] FunctJalr = 6'b001001;
  localparam logic [5:0] FunctAddu = 6'b100001;

  localparam int unsigned DmWords = 1024;

  typedef enum logic [2:0] {
    LdNone,
    LdWord,
    LdHalf,
    LdHalfU,
    LdByte,
    LdByteU
  } load_e;

  function automatic load_e load_kind(input logic [5:0] op);
    case (op)
      OpLw:    return LdWord;
      OpLh:    return LdHalf;
      OpLhu:   return LdHalfU;
      OpLb:    return LdByte;
      OpLbu:   return LdByteU;
      default: return LdNone;
    endcase
  endfunction

endpackage

// File: rtl/dm_byte_ram.sv
// 1024 x 32 data memory with byte-enable store merge; read is combinational.
module dm_byte_ram
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [11:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [31:0] mem [DmWords];
  logic [9:0]  idx;
  logic [3:0]  be;
  logic [31:0] wdata_rep;

  assign idx = addr[11:2];

  // Replicate store data across lanes so each enabled byte picks its own slice.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = '0;
    case (op)
      OpSw: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
      OpSh: begin
        be        = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      OpSb: begin
        be        = 4'b0001 << addr[1:0];
        wdata_rep = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DmWords; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wdata_rep[8*k +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/pipeline_m.sv
// MIPS memory stage: data memory access, load extension, M/W pipeline register, jal forward.
module pipeline_m
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_M,
  input  logic [31:0] ALUOutput_M,
  input  logic [31:0] WriteData_M,
  input  logic [31:0] PCPlus4_M,
  output logic [31:0] Instr_W,
  output logic [31:0] ReadData_W,
  output logic [31:0] ALUOutput_W,
  output logic [31:0] PCPlus4_W,
  output logic [31:0] ForwardData_M
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] ram_word;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_data;

  assign op    = Instr_M[31:26];
  assign funct = Instr_M[5:0];

  dm_byte_ram u_dm (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .addr  (ALUOutput_M[11:0]),
    .wdata (WriteData_M),
    .rdata (ram_word)
  );

  assign half_sel = ALUOutput_M[1] ? ram_word[31:16] : ram_word[15:0];
  assign byte_sel = ram_word[8*ALUOutput_M[1:0] +: 8];

  always_comb begin
    load_data = '0;
    case (load_kind(op))
      LdWord:  load_data = ram_word;
      LdHalf:  load_data = {{16{half_sel[15]}}, half_sel};
      LdHalfU: load_data = {16'h0000, half_sel};
      LdByte:  load_data = {{24{byte_sel[7]}}, byte_sel};
      LdByteU: load_data = {24'h000000, byte_sel};
      default: load_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Instr_W     <= '0;
      ReadData_W  <= '0;
      ALUOutput_W <= '0;
      PCPlus4_W   <= '0;
    end else begin
      Instr_W     <= Instr_M;
      ReadData_W  <= load_data;
      ALUOutput_W <= ALUOutput_M;
      PCPlus4_W   <= PCPlus4_M;
    end
  end

  // Link value for jal/jalr skips the delay slot; deliberately not gated by reset.
  assign ForwardData_M = ((op == OpJal) || ((op == OpSpecial) && (funct == FunctJalr))) ?
                         PCPlus4_M + 32'd4 : ALUOutput_M;

endmodule
